// File: rtl/mmio_machine_timer.sv
// mmio_machine_timer: memory-mapped RISC-V machine timer with 64-bit mtime/mtimecmp and level MTIP output
module mmio_machine_timer #(
   parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_8000,
   parameter int unsigned PRESCALE     = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] bus_address,
   input  logic [31:0] bus_write_data,
   input  logic [3:0]  bus_byte_enable,
   input  logic        bus_read_enable,
   input  logic        bus_write_enable,
   output logic [31:0] bus_read_data,
   output logic        timer_interrupt
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
   logic [63:0]   mtime;
   logic [63:0]   mtimecmp;
   logic [31:0]   shadow_hi;
   logic [1:0]    ctrl;
   logic [PW-1:0] pcount;
   logic [2:0]    offset;
   logic          sel, wr, rd, tick, mtime_wr;
   logic          unused_addr;
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction
   assign sel         = bus_address[31:5] == BASE_ADDRESS[31:5];
   assign offset      = bus_address[4:2];
   assign wr          = sel & bus_write_enable;
   assign rd          = sel & bus_read_enable;
   assign tick        = ctrl[0] & (pcount == PMAX);
   assign mtime_wr    = wr & ((offset == 3'd0) | (offset == 3'd1));
   assign unused_addr = ^bus_address[1:0];
   always_comb begin
      bus_read_data = '0;
      if (rd)
         case (offset)
            3'd0:    bus_read_data = mtime[31:0];
            3'd1:    bus_read_data = mtime[63:32];
            3'd2:    bus_read_data = mtimecmp[31:0];
            3'd3:    bus_read_data = mtimecmp[63:32];
            3'd4:    bus_read_data = {30'd0, ctrl};
            3'd5:    bus_read_data = shadow_hi;
            default: bus_read_data = '0;
         endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         mtime           <= '0;
         mtimecmp        <= '1;
         shadow_hi       <= '0;
         ctrl            <= '0;
         pcount          <= '0;
         timer_interrupt <= 1'b0;
      end else begin
         pcount <= ctrl[0] ? (tick ? '0 : pcount + PW'(1)) : '0;
         // a software write to either mtime half wins over the tick, so no stray carry lands
         if (mtime_wr) begin
            if (offset == 3'd0) mtime[31:0] <= merge(mtime[31:0], bus_write_data, bus_byte_enable);
            else                mtime[63:32] <= merge(mtime[63:32], bus_write_data, bus_byte_enable);
         end else if (tick) begin
            mtime <= mtime + 64'd1;
         end
         if (wr & (offset == 3'd2)) mtimecmp[31:0] <= merge(mtimecmp[31:0], bus_write_data, bus_byte_enable);
         if (wr & (offset == 3'd3)) mtimecmp[63:32] <= merge(mtimecmp[63:32], bus_write_data, bus_byte_enable);
         if (wr & (offset == 3'd4) & bus_byte_enable[0]) ctrl <= bus_write_data[1:0];
         if (rd & (offset == 3'd0)) shadow_hi <= mtime[63:32];
         timer_interrupt <= ctrl[1] & (mtime >= mtimecmp);
      end
   end
endmodule
